enc_rd_ctrl: RTL and testbench

ENC_RD_CTRL -- requirements
Module: enc_rd_ctrl

---
 rtl/enc_rd_ctrl.sv | 142 ++++++++++++++
 tb/tb_enc_rd_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_rd_ctrl.sv
//==============================================================================
// Module      : enc_rd_ctrl
// Description : 8b/10b encoder read controller. Issues lookups to external
//               RD+ and RD- code ROMs, selects the returned word by the
//               current running disparity, classifies it by popcount, tracks
//               RD, counts errors and buffers results in a 2-entry FIFO.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module enc_rd_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       i_data,
    input  logic             i_k,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_rd_init,
    input  logic             i_rd_load,
    output logic [7:0]       o_rom_addr,
    output logic             o_rom_rd_en,
    output logic             o_rom_k,
    input  logic [9:0]       i_plus_out,
    input  logic [9:0]       i_minus_out,
    input  logic             i_plus_k_err,
    input  logic             i_minus_k_err,
    output logic [9:0]       o_code,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_err,
    output logic             o_rd,
    output logic [CNT_W-1:0] o_err_cnt
);

    // Lookup pipeline tracking: one word can be waiting on the ROMs
    logic             r_inflight;
    logic             r_k_d;
    logic             r_rd;
    logic [CNT_W-1:0] r_err_cnt;

    // Output FIFO: each entry holds {err, code}
    logic [10:0]      r_mem [2];
    logic             r_wp;
    logic             r_rp;
    logic [1:0]       r_cnt;

    logic             w_accept;
    logic [9:0]       w_sel_code;
    logic             w_sel_kerr;
    logic [3:0]       w_pop_cnt;
    logic             w_kerr;
    logic             w_derr;
    logic             w_err;
    logic             w_rd_next;
    logic             w_push;
    logic             w_pop;

    // Occupancy plus the word in flight must leave room, so nothing is dropped
    assign o_ready     = ~rst & ((r_cnt + {1'b0, r_inflight}) < 2'd2);
    assign w_accept    = i_valid & o_ready;
    assign o_rom_addr  = i_data;
    assign o_rom_k     = i_k;
    assign o_rom_rd_en = w_accept;

    assign w_sel_code  = r_rd ? i_plus_out   : i_minus_out;
    assign w_sel_kerr  = r_rd ? i_plus_k_err : i_minus_k_err;

    // Popcount of the selected code word
    always_comb begin
        w_pop_cnt = '0;
        for (int i = 0; i < 10; i++) begin
            w_pop_cnt = w_pop_cnt + 4'(w_sel_code[i]);
        end
    end

    // Classify: balanced keeps RD, +2 only from RD-, -2 only from RD+
    always_comb begin
        w_derr    = 1'b0;
        w_rd_next = r_rd;
        case (w_pop_cnt)
            4'd5:    w_rd_next = r_rd;
            4'd6:    if (!r_rd) w_rd_next = 1'b1; else w_derr = 1'b1;
            4'd4:    if (r_rd)  w_rd_next = 1'b0; else w_derr = 1'b1;
            default: w_derr = 1'b1;
        endcase
    end

    assign w_kerr  = w_sel_kerr & r_k_d;
    assign w_err   = w_kerr | w_derr;
    assign w_push  = r_inflight;
    assign w_pop   = o_valid & i_ready;

    assign o_valid   = (r_cnt != 2'd0);
    assign o_code    = o_valid ? r_mem[r_rp][9:0] : 10'd0;
    assign o_err     = o_valid & r_mem[r_rp][10];
    assign o_rd      = r_rd;
    assign o_err_cnt = r_err_cnt;

    // FIFO storage; contents are don't-care until pointed at by a valid count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= {w_err, w_sel_code};
        end
    end

    // Control state: pipeline tracking, FIFO pointers, RD and error count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_k_d      <= 1'b0;
            r_rd       <= 1'b0;
            r_wp       <= 1'b0;
            r_rp       <= 1'b0;
            r_cnt      <= 2'd0;
            r_err_cnt  <= '0;
        end else begin
            r_inflight <= w_accept;
            r_k_d      <= i_k;
            if (w_push) r_wp <= ~r_wp;
            if (w_pop)  r_rp <= ~r_rp;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
            // An explicit load wins over the word's own RD update
            if (i_rd_load) begin
                r_rd <= i_rd_init;
            end else if (w_push && !w_err) begin
                r_rd <= w_rd_next;
            end
            if (w_push && w_err && (r_err_cnt != {CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_enc_rd_ctrl.sv
//==============================================================================
// Module      : tb_enc_rd_ctrl
// Description : Scoreboard bench for enc_rd_ctrl with behavioural ROM model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_enc_rd_ctrl;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       i_data;
    logic             i_k;
    logic             i_valid;
    logic             o_ready;
    logic             i_rd_init;
    logic             i_rd_load;
    logic [7:0]       o_rom_addr;
    logic             o_rom_rd_en;
    logic             o_rom_k;
    logic [9:0]       i_plus_out;
    logic [9:0]       i_minus_out;
    logic             i_plus_k_err;
    logic             i_minus_k_err;
    logic [9:0]       o_code;
    logic             o_valid;
    logic             i_ready;
    logic             o_err;
    logic             o_rd;
    logic [CNT_W-1:0] o_err_cnt;

    enc_rd_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_k(i_k), .i_valid(i_valid),
        .o_ready(o_ready), .i_rd_init(i_rd_init), .i_rd_load(i_rd_load),
        .o_rom_addr(o_rom_addr), .o_rom_rd_en(o_rom_rd_en), .o_rom_k(o_rom_k),
        .i_plus_out(i_plus_out), .i_minus_out(i_minus_out),
        .i_plus_k_err(i_plus_k_err), .i_minus_k_err(i_minus_k_err),
        .o_code(o_code), .o_valid(o_valid), .i_ready(i_ready), .o_err(o_err),
        .o_rd(o_rd), .o_err_cnt(o_err_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ROM contents: K28.5 real codes, other K lookups flag an error,
    // data words get a popcount class derived from the address.
    function automatic logic [10:0] rom_word(input logic [7:0] a, input logic k, input logic plus);
        logic [9:0] c;
        int p;
        int r;
        if (k) begin
            if (a == 8'hBC) return {1'b0, plus ? 10'b1100000101 : 10'b0011111010};
            return {1'b1, plus ? 10'b1010101010 : 10'b0101010101};
        end
        case ((a ^ (plus ? 8'h5A : 8'h00)) % 8)
            0, 1, 2: p = 5;
            3, 4:    p = 6;
            5, 6:    p = 4;
            default: p = a[0] ? 3 : 7;
        endcase
        c = '0;
        for (int i = 0; i < p; i++) c[i] = 1'b1;
        r = a % 10;
        c = (c << r) | (c >> (10 - r));
        return {1'b0, c};
    endfunction

    // Registered ROM pair, one-cycle read latency
    always @(posedge clk) begin
        if (o_rom_rd_en) begin
            {i_plus_k_err,  i_plus_out}  <= rom_word(o_rom_addr, o_rom_k, 1'b1);
            {i_minus_k_err, i_minus_out} <= rom_word(o_rom_addr, o_rom_k, 1'b0);
        end
    end

    // Reference model: expected {err, code} queue, RD and error count
    logic [10:0] q[$];
    logic        pend = 1'b0;
    logic [7:0]  pa;
    logic        pk;
    logic        mrd = 1'b0;
    int          mcnt = 0;

    always @(posedge clk) begin
        logic [10:0] w;
        logic        ok;
        logic        nrd;
        int          p;
        if (rst) begin
            q.delete();
            pend = 1'b0;
            mrd  = 1'b0;
            mcnt = 0;
        end else begin
            nrd = mrd;
            if (pend) begin
                w  = rom_word(pa, pk, mrd);
                p  = $countones(w[9:0]);
                ok = !(w[10] && pk) && (p == 5 || (p == 6 && !mrd) || (p == 4 && mrd));
                q.push_back({!ok, w[9:0]});
                if (ok && p != 5) nrd = !mrd;
                if (!ok && mcnt != CMAX) mcnt++;
            end
            if (i_rd_load) nrd = i_rd_init;
            mrd  = nrd;
            pend = i_valid && o_ready;
            pa   = i_data;
            pk   = i_k;
        end
    end

    // Monitor: flow control, status and popped words against the model
    always @(negedge clk) begin
        logic [10:0] e;
        if (!rst) begin
            check("ready", o_ready, (q.size() + pend) < 2);
            check("valid", o_valid, q.size() != 0);
            check("rd", o_rd, mrd);
            check("err_cnt", o_err_cnt, mcnt);
            if (o_rom_rd_en) check("rom_addr", {o_rom_k, o_rom_addr}, {i_k, i_data});
            if (o_valid && i_ready) begin
                if (q.size() == 0) begin
                    check("stale_word", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("code", o_code, e[9:0]);
                    check("err", o_err, e[10]);
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one word and hold it until accepted (bounded)
    task automatic send(input logic [7:0] d, input logic k);
        logic got;
        got     = 1'b0;
        i_data  = d;
        i_k     = k;
        i_valid = 1'b1;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (o_ready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        if (!got) check("send_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; i_data = 8'h00; i_k = 1'b0; i_valid = 1'b0;
        i_rd_init = 1'b0; i_rd_load = 1'b0; i_ready = 1'b1;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", o_valid, 0);
        check("rst_ready", o_ready, 1);
        check("rst_rom_en", o_rom_rd_en, 0);
        check("rst_rd", o_rd, 0);
        check("rst_err", o_err, 0);
        check("rst_cnt", o_err_cnt, 0);
        @(posedge clk); #1;

        // K28.5 from RD-: 2-cycle latency and the RD- code
        i_data = 8'hBC; i_k = 1'b1; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(negedge clk);
        check("lat_n1_valid", o_valid, 0);
        @(negedge clk);
        check("lat_n2_valid", o_valid, 1);
        check("k285_minus", o_code, 10'b0011111010);
        tick(2);
        check("k285_rd_plus", o_rd, 1);
        send(8'hBC, 1'b1);
        tick(3);
        check("k285_rd_minus", o_rd, 0);

        // Bad K lookup, then a P=4 word from RD-
        send(8'h00, 1'b1);
        tick(3);
        check("kerr_cnt", o_err_cnt, 1);
        check("kerr_rd", o_rd, 0);
        send(8'h05, 1'b0);
        tick(3);
        check("derr_cnt", o_err_cnt, 2);
        check("derr_rd", o_rd, 0);

        // RD load coincident with a P=6 update, then K28.5 from RD+
        send(8'hBC, 1'b1);
        i_rd_load = 1'b1; i_rd_init = 1'b1;
        tick(1);
        i_rd_load = 1'b0;
        check("load_rd", o_rd, 1);
        send(8'hBC, 1'b1);
        tick(3);

        // Backpressure: stream 4 words while downstream stalls
        i_ready = 1'b0;
        fork
            begin
                send(8'hBC, 1'b1);
                send(8'h12, 1'b0);
                send(8'h23, 1'b0);
                send(8'hBC, 1'b1);
            end
            begin
                tick(20);
                i_ready = 1'b1;
            end
        join
        tick(6);

        // Reset with buffered and in-flight words
        i_ready = 1'b0;
        send(8'hBC, 1'b1);
        send(8'h11, 1'b0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", o_valid, 0);
        check("midrst_rd", o_rd, 0);
        i_ready = 1'b1;
        tick(6);

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            i_valid   = $urandom_range(0, 1);
            i_k       = ($urandom_range(0, 2) == 0);
            i_data    = ($urandom_range(0, 3) == 0) ? 8'hBC : 8'($urandom);
            i_ready   = ($urandom_range(0, 3) != 0);
            i_rd_load = ($urandom_range(0, 19) == 0);
            i_rd_init = $urandom_range(0, 1);
            tick(1);
        end
        i_valid = 1'b0; i_rd_load = 1'b0; i_ready = 1'b1;
        tick(5);

        // Error counter saturation
        for (int j = 0; j < CMAX + 3; j++) send(8'h00, 1'b1);
        tick(4);
        check("sat_cnt", o_err_cnt, CMAX);
        check("drain", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
